// File: rtl/store_buffer.sv
// store_buffer: posted-write FIFO between CPU and data memory, with store
// coalescing into the youngest entry and bitwise load forwarding.
module store_buffer #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32,
  parameter int Depth     = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cpuWrite,
  input  logic [AddrWidth-1:0]         cpuAddr,
  input  logic [DataWidth-1:0]         cpuWData,
  input  logic [DataWidth-1:0]         cpuWMask,
  output logic [DataWidth-1:0]         cpuRData,
  output logic                         cpuStall,
  output logic [AddrWidth-1:0]         memRAddr,
  input  logic [DataWidth-1:0]         memRData,
  output logic                         memWValid,
  input  logic                         memWReady,
  output logic [AddrWidth-1:0]         memWAddr,
  output logic [DataWidth-1:0]         memWData,
  output logic [DataWidth-1:0]         memWMask,
  output logic [$clog2(Depth+1)-1:0]   count,
  output logic                         empty
);
  localparam int PW = $clog2(Depth);
  localparam int CW = $clog2(Depth + 1);

  logic [AddrWidth-1:0] addr_q [Depth];
  logic [DataWidth-1:0] data_q [Depth];
  logic [DataWidth-1:0] mask_q [Depth];
  logic [PW-1:0]        head, tail, young;
  logic                 full, merge, push, pop;

  assign young     = tail - PW'(1);
  assign full      = count == CW'(Depth);
  assign empty     = count == '0;
  // with two or more entries the youngest is never the head, so merging is safe during a drain
  assign merge     = cpuWrite && count >= CW'(2) &&
                     addr_q[young][AddrWidth-1:2] == cpuAddr[AddrWidth-1:2];
  assign push      = cpuWrite && !merge && !full;
  assign cpuStall  = cpuWrite && full && !merge;
  assign memWValid = !empty;
  assign pop       = memWValid && memWReady;
  assign memWAddr  = addr_q[head];
  assign memWData  = data_q[head];
  assign memWMask  = mask_q[head];
  assign memRAddr  = cpuAddr;

  always_comb begin
    cpuRData = memRData;
    for (int i = 0; i < Depth; i++) begin
      cpuRData = (CW'(i) < count &&
                  addr_q[head + PW'(i)][AddrWidth-1:2] == cpuAddr[AddrWidth-1:2]) ?
                 (cpuRData & ~mask_q[head + PW'(i)]) |
                 (data_q[head + PW'(i)] & mask_q[head + PW'(i)]) : cpuRData;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
        mask_q[i] <= '0;
      end
    end else begin
      if (push) begin
        addr_q[tail] <= cpuAddr;
        data_q[tail] <= cpuWData;
        mask_q[tail] <= cpuWMask;
        tail         <= tail + PW'(1);
      end
      if (merge) begin
        data_q[young] <= (data_q[young] & ~cpuWMask) | (cpuWData & cpuWMask);
        mask_q[young] <= mask_q[young] | cpuWMask;
      end
      if (pop) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed vectors with hand-computed expectations.
module tb_store_buffer;
  logic        clock = 0, reset = 0;
  logic        cpuWrite = 0, cpuStall, memWValid, memWReady = 0, empty;
  logic [31:0] cpuAddr = 0, cpuWData = 0, cpuWMask = 0, cpuRData, memRAddr, memRData = 0;
  logic [31:0] memWAddr, memWData, memWMask;
  logic [2:0]  count;
  int checks = 0, failures = 0;

  store_buffer dut (
    .clock(clock), .reset(reset), .cpuWrite(cpuWrite), .cpuAddr(cpuAddr),
    .cpuWData(cpuWData), .cpuWMask(cpuWMask), .cpuRData(cpuRData), .cpuStall(cpuStall),
    .memRAddr(memRAddr), .memRData(memRData), .memWValid(memWValid), .memWReady(memWReady),
    .memWAddr(memWAddr), .memWData(memWData), .memWMask(memWMask), .count(count), .empty(empty)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] m);
    cpuWrite = 1; cpuAddr = a; cpuWData = d; cpuWMask = m;
    @(posedge clock); #1;
    cpuWrite = 0;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [31:0] rd, input logic [31:0] exp);
    cpuAddr = a; memRData = rd; #1;
    check(tag, cpuRData, exp);
    check({tag, "_raddr"}, memRAddr, a);
  endtask

  task automatic drain();
    memWReady = 1;
    for (int i = 0; i < 20 && !empty; i++) begin
      @(posedge clock); #1;
    end
    check("drain_empty", empty, 1);
    memWReady = 0;
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1; #1;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_valid", memWValid, 0);
    cpuWrite = 1; #1;
    check("rst_nostall", cpuStall, 0);
    cpuWrite = 0;
    @(posedge clock); #1;

    store(32'h10, 32'h11111111, '1);
    store(32'h14, 32'h22222222, '1);
    store(32'h18, 32'h33333333, '1);
    check("q_count", count, 3);
    load("q_fwd", 32'h14, 0, 32'h22222222);
    check("q_head0", memWAddr, 32'h10);
    check("q_data0", memWData, 32'h11111111);
    memWReady = 1;
    @(posedge clock); #1 check("q_head1", memWAddr, 32'h14);
    @(posedge clock); #1 check("q_head2", memWAddr, 32'h18);
    @(posedge clock); #1 check("q_empty", empty, 1);
    check("q_novalid", memWValid, 0);
    memWReady = 0;

    store(32'h40, 32'h40, '1);
    store(32'h44, 32'h44, '1);
    store(32'h48, 32'h48, '1);
    store(32'h4C, 32'h4C, '1);
    cpuWrite = 1; cpuAddr = 32'h50; cpuWData = 32'h50; cpuWMask = '1; #1;
    check("full_stall", cpuStall, 1);
    check("full_count", count, 4);
    memWReady = 1; #1;
    check("full_stall_ready", cpuStall, 1);
    @(posedge clock); #1;
    memWReady = 0; #1;
    check("full_popped", count, 3);
    check("full_unstall", cpuStall, 0);
    check("full_head", memWAddr, 32'h44);
    @(posedge clock); #1;
    cpuWrite = 0;
    check("full_accept", count, 4);
    load("full_fwd5", 32'h50, 32'hFFFFFFFF, 32'h50);
    drain();

    store(32'h20, 32'h11, 32'hFF);
    store(32'h24, 32'h00, 32'hFF);
    store(32'h24, 32'h2200, 32'hFF00);
    check("co_count", count, 2);
    check("co_head", memWAddr, 32'h20);
    load("co_fwd", 32'h24, 32'hAAAAAAAA, 32'hAAAA2200);
    load("co_fwd_other", 32'h20, 32'hAAAAAAAA, 32'hAAAAAA11);
    drain();

    store(32'h30, 32'hAAAAAAAA, '1);
    store(32'h34, 32'h34343434, '1);
    store(32'h30, 32'h0000BBBB, 32'h0000FFFF);
    check("pr_count", count, 3);
    load("pr_fwd", 32'h30, 0, 32'hAAAABBBB);
    load("pr_byteoff", 32'h33, 0, 32'hAAAABBBB);
    load("pr_mid", 32'h34, 0, 32'h34343434);
    load("pr_miss", 32'h38, 32'h12345678, 32'h12345678);
    memWReady = 1;
    store(32'h60, 32'h60, '1);
    check("pp_count", count, 3);
    check("pp_head", memWAddr, 32'h34);
    memWReady = 0;
    drain();

    store(32'h70, 32'h77, '1);
    store(32'h74, 32'h78, '1);
    check("rd_valid", memWValid, 1);
    #3 reset = 0; #1;
    check("rd_async_valid", memWValid, 0);
    check("rd_async_count", count, 0);
    repeat (2) @(posedge clock);
    #1 reset = 1;
    @(posedge clock); #1;
    check("rd_count", count, 0);
    check("rd_novalid", memWValid, 0);
    load("rd_nofwd", 32'h70, 32'h55, 32'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the CPU data-memory port and the data RAM/bus.
- CPU stores are queued in a small FIFO and drained to memory over a valid/ready handshake, so a slow memory does not hold up the single-cycle core.
- Loads read the RAM combinationally. Pending buffered stores are forwarded bit-by-bit on top of the RAM data.
- cpuStall is wired into the CPU enable (enable = ~cpuStall).

Parameters:
DataWidth, 32, data word width in bits
AddrWidth, 32, data address width (byte address)
Depth, 4, number of buffer entries; power of two, at least 2

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cpuWrite  in  1  CPU store strobe
cpuAddr  in  AddrWidth  CPU data byte address (store or load)
cpuWData  in  DataWidth  CPU store data
cpuWMask  in  DataWidth  per-bit store mask
cpuRData  out  DataWidth  load data returned to CPU (forwarded)
cpuStall  out  1  store cannot be accepted; CPU must hold
memRAddr  out  AddrWidth  RAM read address (equals cpuAddr)
memRData  in  DataWidth  RAM read data (combinational)
memWValid  out  1  head entry presented to memory
memWReady  in  1  memory accepts head entry
memWAddr  out  AddrWidth  head entry address
memWData  out  DataWidth  head entry data
memWMask  out  DataWidth  head entry per-bit mask
count  out  $clog2(Depth+1)  occupied entries
empty  out  1  count == 0

Behaviour:
- Entry = {addr, data, mask}. Circular FIFO with head/tail pointers and count. Pointers wrap modulo Depth.
- Word match: two addresses match when addr[AddrWidth-1:2] is equal. Byte offset bits are ignored.
- Reset (reset low, asynchronous):
  - count=0, empty=1, memWValid=0, pointers=0, all entry masks cleared.
  - memWValid drops immediately, even mid-handshake; pending entries are discarded.
- Drain:
  - memWValid = ~empty. memWAddr/memWData/memWMask come from the head entry.
  - Pop happens on a clock edge with memWValid & memWReady.
  - Head fields are stable while memWValid=1 and not popped.
- Merge (coalesce) condition, evaluated combinationally: cpuWrite & count>=2 & cpuAddr matches the youngest entry (tail-1).
  - The youngest entry is never the head in this case, so presented data never changes.
  - On the clock edge: data = (old & ~cpuWMask) | (cpuWData & cpuWMask); mask |= cpuWMask; count unchanged.
- Enqueue: cpuWrite & ~merge & ~full → on the clock edge, write {cpuAddr, cpuWData, cpuWMask} at tail and advance tail.
- Stall:
  - cpuStall = cpuWrite & full & ~merge. Combinational, and independent of memWReady (no same-cycle pop/push bypass when full).
  - A stalled store is not captured. The CPU re-presents it next cycle.
- Simultaneous events:
  - Pop and enqueue in the same cycle when not full: count unchanged, both pointers advance.
  - Pop and merge in the same cycle are legal, because merge never targets the head.
- Load forwarding (combinational):
  - memRAddr = cpuAddr.
  - cpuRData starts from memRData. Every valid entry whose address matches cpuAddr is applied from oldest to youngest: r = (r & ~mask) | (data & mask). Youngest wins.
  - The head is still included while it is being popped in the current cycle.
  - Forwarding is active whenever cpuWrite=0. It is don't-care when cpuWrite=1.
- count/empty are registered-state derived. cpuStall has no reset value of its own: it is 0 whenever cpuWrite=0 or the buffer is not full.
- No ordering against RAM reads: the RAM only sees drained writes; forwarding covers all pending writes.

Test Plan:
- Reset state: hold reset low 3 cycles, then release → count=0, empty=1, memWValid=0. With cpuWrite=1, count=0 → cpuStall=0.
- Queue and forward: memWReady=0; store 0x10/0x11111111, 0x14/0x22222222, 0x18/0x33333333, all with full mask → count=3. Load 0x14 with memRData=0 → cpuRData=0x22222222. Then memWReady=1 → memWAddr 0x10, 0x14, 0x18 on three consecutive edges; then empty=1.
- Full stall: Depth=4, memWReady=0, five stores to distinct words → fifth cycle cpuStall=1, count=4. Pulse memWReady for one cycle → count=3, cpuStall=0, and the fifth store is accepted on the next edge (count=4).
- Coalesce:
  - Setup: memWReady=0; store 0x20/0x11, mask 0xFF; store 0x24/0x00, mask 0xFF.
  - Stimulus: store 0x24/0x2200, mask 0xFF00.
  - Required: count stays 2.
  - Required: load 0x24 with memRData=0xAAAAAAAA → cpuRData=0xAAAA2200.
- Forward priority:
  - Stores (memWReady=0): 0x30/0xAAAAAAAA full mask; then 0x34; then 0x30/0x0000BBBB, mask 0x0000FFFF (no merge, since 0x30 is not youngest).
  - Required: load 0x30 with memRData=0 → 0xAAAABBBB.
- Reset mid-drain: two entries queued, memWValid=1, memWReady=0; assert reset asynchronously mid-cycle → memWValid=0 immediately. After release, count=0 and no write is presented.
